// File: rtl/fetch_unit_pkg.sv
// Shared widths and FSM encodings for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} FIFO between memory responses and decode.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [ILEN-1:0] i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [ILEN-1:0] o_instr,
  output logic [1:0]      o_count
);

  logic [XLEN-1:0] r_pc    [2];
  logic [ILEN-1:0] r_instr [2];
  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_pc[r_wr_ptr]    <= i_pc;
        r_instr[r_wr_ptr] <= i_instr;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pc    = r_pc[r_rd_ptr];
  assign o_instr = r_instr[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding request, redirect flush, 2-deep buffer.
// state  | meaning
// S_REQ  | no request outstanding, may issue when buffer has room
// S_WAIT | one request outstanding, response is pushed
// S_DROP | one request outstanding, response is discarded (redirected)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_PCSrc,
  input  logic [XLEN-1:0] i_branch_target,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [ILEN-1:0] i_imem_rdata,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc
);

  localparam logic [1:0] LP_DEPTH = 2'(BUF_DEPTH);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_tag_pc;

  logic            w_req;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count;
  logic [XLEN-1:0] w_head_pc;
  logic [ILEN-1:0] w_head_instr;
  logic [XLEN-1:0] w_target;

  assign w_target = i_branch_target & ~32'h0000_0003;

  // Gated by reset so no request is presented while reset is held.
  assign w_req   = i_rst_n && (r_state == S_REQ) && (w_count < LP_DEPTH) && !i_PCSrc;
  assign w_valid = (w_count != 2'd0) && !i_PCSrc;
  assign w_push  = (r_state == S_WAIT) && i_imem_rvalid && !i_PCSrc;
  assign w_pop   = w_valid && i_instr_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_REQ;
      r_fpc    <= RESET_PC;
      r_tag_pc <= '0;
    end else if (i_PCSrc) begin
      r_fpc   <= w_target;
      r_state <= ((r_state != S_REQ) && !i_imem_rvalid) ? S_DROP : S_REQ;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_req && i_imem_gnt) begin
            r_tag_pc <= r_fpc;
            r_fpc    <= r_fpc + 32'd4;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (i_imem_rvalid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  fetch_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_PCSrc),
    .i_pc    (r_tag_pc),
    .i_instr (i_imem_rdata),
    .o_pc    (w_head_pc),
    .o_instr (w_head_instr),
    .o_count (w_count)
  );

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_fpc;
  assign o_instr_valid = w_valid;
  assign o_instr       = w_valid ? w_head_instr : '0;
  assign o_instr_pc    = w_valid ? w_head_pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench plays memory and decode by hand.
module tb_fetch_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_PCSrc;
  logic [31:0] i_branch_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;

  int n_total = 0;
  int n_bad   = 0;

  fetch_unit dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_PCSrc         (i_PCSrc),
    .i_branch_target (i_branch_target),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_gnt      (i_imem_gnt),
    .i_imem_rvalid   (i_imem_rvalid),
    .i_imem_rdata    (i_imem_rdata),
    .o_instr_valid   (o_instr_valid),
    .i_instr_ready   (i_instr_ready),
    .o_instr         (o_instr),
    .o_instr_pc      (o_instr_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins);
    chk({tag, "_valid"}, {31'd0, o_instr_valid}, {31'd0, v});
    chk({tag, "_pc"}, o_instr_pc, pc);
    chk({tag, "_instr"}, o_instr, ins);
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, o_imem_req}, {31'd0, r});
    chk({tag, "_addr"}, o_imem_addr, addr);
  endtask

  // Called at a falling edge: grant one request, answer it next cycle.
  task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data);
    #1 chk_req({tag, "_issue"}, 1'b1, addr);
    i_imem_gnt = 1'b1;
    @(negedge i_clk);
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = data;
    #1 chk({tag, "_wait_req"}, {31'd0, o_imem_req}, 32'd0);
    @(negedge i_clk);
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_PCSrc = 1'b0; i_branch_target = 32'h0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    i_instr_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    #1 chk_req("rst", 1'b0, 32'h0);
    chk_out("rst", 1'b0, 32'h0, 32'h0);

    // in-order streaming, ready held high
    @(negedge i_clk);
    i_rst_n = 1'b1; i_instr_ready = 1'b1;
    fetch_one("a0", 32'h0, 32'h1111_0000);
    #1 chk_out("a0", 1'b1, 32'h0, 32'h1111_0000);
    fetch_one("a1", 32'h4, 32'h2222_0004);
    #1 chk_out("a1", 1'b1, 32'h4, 32'h2222_0004);
    fetch_one("a2", 32'h8, 32'h3333_0008);
    #1 chk_out("a2", 1'b1, 32'h8, 32'h3333_0008);
    @(negedge i_clk);
    i_instr_ready = 1'b0;
    #1 chk_out("a_drain", 1'b0, 32'h0, 32'h0);
    chk_req("a_drain", 1'b1, 32'hC);

    // decode stalled: buffer fills to two and requests stop
    fetch_one("b0", 32'hC, 32'hD000_000C);
    #1 chk_out("b0", 1'b1, 32'hC, 32'hD000_000C);
    fetch_one("b1", 32'h10, 32'hD100_0010);
    #1 chk_req("b_full", 1'b0, 32'h14);
    chk_out("b_full", 1'b1, 32'hC, 32'hD000_000C);
    i_imem_gnt = 1'b1;
    @(negedge i_clk);
    #1 chk_req("b_full2", 1'b0, 32'h14);
    i_imem_gnt = 1'b0;
    i_instr_ready = 1'b1;
    @(negedge i_clk);
    #1 chk_out("b_pop1", 1'b1, 32'h10, 32'hD100_0010);
    chk_req("b_pop1", 1'b1, 32'h14);
    @(negedge i_clk);
    #1 chk_out("b_pop2", 1'b0, 32'h0, 32'h0);
    fetch_one("b2", 32'h14, 32'hD200_0014);
    #1 chk_out("b2", 1'b1, 32'h14, 32'hD200_0014);

    // redirect while waiting: in-flight response is dropped
    i_imem_gnt = 1'b1;
    @(negedge i_clk);
    i_imem_gnt = 1'b0; i_PCSrc = 1'b1; i_branch_target = 32'h0000_0103;
    #1 chk_req("c_redir", 1'b0, 32'h1C);
    chk_out("c_redir", 1'b0, 32'h0, 32'h0);
    @(negedge i_clk);
    i_PCSrc = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0_0018;
    #1 chk_req("c_drop", 1'b0, 32'h100);
    @(negedge i_clk);
    i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    #1 chk_out("c_after", 1'b0, 32'h0, 32'h0);
    fetch_one("c0", 32'h100, 32'hE000_0100);
    #1 chk_out("c0", 1'b1, 32'h100, 32'hE000_0100);

    // redirect coincident with rvalid, buffer non-empty
    i_instr_ready = 1'b0;
    i_imem_gnt = 1'b1;
    @(negedge i_clk);
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD1_0104;
    i_PCSrc = 1'b1; i_branch_target = 32'h0000_0200;
    #1 chk_out("d_redir", 1'b0, 32'h0, 32'h0);
    chk_req("d_redir", 1'b0, 32'h108);
    @(negedge i_clk);
    i_imem_rvalid = 1'b0; i_PCSrc = 1'b0; i_imem_rdata = 32'h0;
    #1 chk_out("d_after", 1'b0, 32'h0, 32'h0);
    fetch_one("d0", 32'h200, 32'hE100_0200);
    #1 chk_out("d0", 1'b1, 32'h200, 32'hE100_0200);

    // wrap from top of address space, unaligned target
    i_instr_ready = 1'b1; i_PCSrc = 1'b1; i_branch_target = 32'hFFFF_FFFF;
    #1 chk_req("e_redir", 1'b0, 32'h204);
    @(negedge i_clk);
    i_PCSrc = 1'b0;
    #1 chk_out("e_flush", 1'b0, 32'h0, 32'h0);
    fetch_one("e0", 32'hFFFF_FFFC, 32'hF00D_FFFC);
    #1 chk_out("e0", 1'b1, 32'hFFFF_FFFC, 32'hF00D_FFFC);
    chk_req("e_wrap", 1'b1, 32'h0);

    // reset while waiting with one entry buffered
    i_instr_ready = 1'b0;
    i_imem_gnt = 1'b1;
    @(negedge i_clk);
    i_imem_gnt = 1'b0; i_rst_n = 1'b0;
    #1 chk_req("f_rst", 1'b0, 32'h0);
    chk_out("f_rst", 1'b0, 32'h0, 32'h0);
    @(negedge i_clk);
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD2_0000;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 chk_req("f_rel", 1'b1, 32'h0);
    chk_out("f_rel", 1'b0, 32'h0, 32'h0);
    @(negedge i_clk);
    i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    #1 chk_out("f_stale", 1'b0, 32'h0, 32'h0);
    fetch_one("f0", 32'h0, 32'hF000_0000);
    #1 chk_out("f0", 1'b1, 32'h0, 32'hF000_0000);
    chk_req("f0_next", 1'b1, 32'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the instruction buffer depth; only 2 is supported.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_PCSrc  input  1  redirect request from the branch unit; takes the target this cycle.
REQ-006 i_branch_target  input  32  redirect address, sampled when i_PCSrc=1.
REQ-007 o_imem_req  output  1  instruction memory request valid.
REQ-008 o_imem_addr  output  32  request address, word aligned.
REQ-009 i_imem_gnt  input  1  memory accepts the request this cycle.
REQ-010 i_imem_rvalid  input  1  read data valid; at most one response per granted request, in order.
REQ-011 i_imem_rdata  input  32  read data.
REQ-012 o_instr_valid  output  1  instruction available to decode.
REQ-013 i_instr_ready  input  1  decode accepts the instruction this cycle.
REQ-014 o_instr  output  32  instruction word; 32'h0 when o_instr_valid=0.
REQ-015 o_instr_pc  output  32  PC of o_instr; 32'h0 when o_instr_valid=0.

Function
REQ-016 Internal fetch PC register fpc; o_imem_addr = fpc at all times.
REQ-017 At most one outstanding memory request.
REQ-018 FSM states: S_REQ (no outstanding request), S_WAIT (one outstanding), S_DROP (one outstanding, response to be discarded).
REQ-019 S_REQ: o_imem_req=1 iff buffer count < 2 and i_PCSrc=0. If o_imem_req=1 and i_imem_gnt=1, tag_pc <= fpc, fpc <= fpc+4 (mod 2^32), go to S_WAIT.
REQ-020 S_WAIT: o_imem_req=0. On i_imem_rvalid, push {tag_pc, i_imem_rdata} into the buffer and go to S_REQ. The buffer is guaranteed to have space because requests are only issued when count < 2.
REQ-021 S_DROP: o_imem_req=0. On i_imem_rvalid, discard the data, do not push, and go to S_REQ.
REQ-022 Redirect (i_PCSrc=1) in any state:
- fpc <= {i_branch_target[31:2], 2'b00}.
- Buffer flushed to count 0.
- Next state: S_WAIT or S_DROP without rvalid this cycle -> S_DROP. Otherwise -> S_REQ.
REQ-023 Redirect overrides any rvalid or pop in the same cycle. No push occurs.
REQ-024 During a redirect cycle, o_instr_valid is forced to 0.
REQ-025 Buffer is a 2-entry FIFO of {pc, instr}. o_instr_valid = (count != 0) & ~i_PCSrc. o_instr and o_instr_pc show the head entry.
REQ-026 Pop when o_instr_valid & i_instr_ready.
REQ-027 Simultaneous push and pop at count=1 or count=2 is legal; count is unchanged.
REQ-028 Latency: request granted in cycle N with rvalid in cycle M gives o_instr_valid=1 in cycle M+1.
REQ-029 A push into an empty buffer is never bypassed to the outputs.
REQ-030 Sustained throughput is one instruction per 2 cycles when the memory has single-cycle response.
REQ-031 fpc wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no error.

Reset
REQ-032 While i_rst_n=0:
- state=S_REQ, fpc=RESET_PC, count=0.
- o_imem_req=0, o_instr_valid=0, o_instr=0, o_instr_pc=0.
REQ-033 Reset asserted mid-transaction abandons the outstanding request. Any later rvalid with no outstanding request (state S_REQ) is ignored.
REQ-034 First request (o_imem_req=1, addr=RESET_PC) is issued in the first cycle after i_rst_n rises.

Structure
REQ-035 The shared defines package holds the XLEN (32) constant, the instruction width, and the FSM state encodings.
REQ-036 The buffer is implemented as sub-module fetch_fifo (2-entry, push/pop/flush, count output), instantiated once.
REQ-037 All other logic (FSM, fpc, tag_pc) resides in fetch_unit. There are no combinational paths from i_imem_rdata to any output.

Verification
REQ-038 Reset release, gnt=1 always, rvalid one cycle after gnt, ready=1 -> o_imem_addr sequence 0,4,8; o_instr_pc sequence 0,4,8 with the matching rdata.
REQ-039 ready=0 held -> after two fills, o_imem_req stays 0 with count=2. Asserting ready then gives two pops in order and resumes fetching.
REQ-040 Redirect to 32'h0000_0103 while in S_WAIT -> next rvalid data never appears, and the next request address is 32'h0000_0100.
REQ-041 Redirect coincident with rvalid -> data discarded, state S_REQ, the next request goes to the target, and o_instr_valid=0 in that cycle.
REQ-042 fpc=32'hFFFF_FFFC granted -> the next request address is 32'h0000_0000.
REQ-043 Assert i_rst_n=0 while in S_WAIT with count=1, then release -> outputs show reset values, and fetch restarts at RESET_PC with count=0.
